// File: rtl/tfe_host_driver.sv
// rtl/tfe_host_driver.sv - host-side job sequencer for the TensorFlowE core port set
//
// Purpose:
//   Runs one job per accepted start. The core is cleared, then n_ops operand bytes
//   are streamed into it. Next the accumulate phase is held for ACC_CYCLES cycles.
//   Finally n_res result bytes are read back one at a time and offered on a
//   valid/ready result stream. All outputs are registered.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start, n_ops, n_res        job request (sampled only when idle) and its byte counts
//   in_data/in_valid/in_ready  operand byte stream into the driver
//   core_datos_in              byte presented to the core Datos_in
//   core_ena_write             core Ena_write strobe
//   core_clear                 core clear strobe
//   core_enable_accu           core enable_accu level
//   core_ena_read              core Ena_read strobe
//   core_datos_out             core Datos_out
//   core_ena_out               core Ena_out (result valid)
//   res_data/res_valid/res_ready  result byte stream out of the driver
//   busy                       high while a job is in flight
//   done                       one-cycle pulse at job end
//   err                        read timeout, sticky until the next accepted start
//
// Configuration:
//   TFE_DRV_TIMEOUT_EN - when defined, a read gives up after TIMEOUT cycles without
//   core_ena_out. err is set, the remaining reads are skipped and the job ends.
//   When undefined, reads wait indefinitely and err stays 0.

module tfe_host_driver #(
    parameter int CNT_W      = 4,
    parameter int ACC_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_ops,
    input  logic [CNT_W-1:0] n_res,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       core_datos_in,
    output logic             core_ena_write,
    output logic             core_clear,
    output logic             core_enable_accu,
    output logic             core_ena_read,
    input  logic [7:0]       core_datos_out,
    input  logic             core_ena_out,
    output logic [7:0]       res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int ACC_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WR,
        S_ACC,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_ops_rem;
    logic [CNT_W-1:0] r_res_rem;
    logic [ACC_W-1:0] r_acc_cnt;
    logic             r_in_ready;
    logic [7:0]       r_datos_in;
    logic             r_ena_write;
    logic             r_clear;
    logic             r_accu;
    logic             r_ena_read;
    logic [7:0]       r_res_data;
    logic             r_res_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_ops_rem_nxt;
    logic [CNT_W-1:0] w_res_rem_nxt;
    logic [ACC_W-1:0] w_acc_cnt_nxt;
    logic             w_in_ready_nxt;
    logic [7:0]       w_datos_in_nxt;
    logic             w_ena_write_nxt;
    logic             w_clear_nxt;
    logic             w_accu_nxt;
    logic             w_ena_read_nxt;
    logic [7:0]       w_res_data_nxt;
    logic             w_res_valid_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_hs;

`ifdef TFE_DRV_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]  r_to_cnt;
    logic [TO_W-1:0]  w_to_cnt_nxt;
`endif

    // in_ready is only ever high in WR, so this is the operand handshake.
    assign w_hs = r_in_ready && in_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_ops_rem_nxt   = r_ops_rem;
        w_res_rem_nxt   = r_res_rem;
        w_acc_cnt_nxt   = r_acc_cnt;
        w_in_ready_nxt  = 1'b0;
        w_datos_in_nxt  = r_datos_in;
        w_ena_write_nxt = 1'b0;
        w_clear_nxt     = 1'b0;
        w_accu_nxt      = 1'b0;
        w_ena_read_nxt  = 1'b0;
        w_res_data_nxt  = r_res_data;
        w_res_valid_nxt = r_res_valid;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;
`ifdef TFE_DRV_TIMEOUT_EN
        w_to_cnt_nxt    = r_to_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ops_rem_nxt = n_ops;
                    w_res_rem_nxt = n_res;
                    w_err_nxt     = 1'b0;
                    w_clear_nxt   = 1'b1;
                    w_state_nxt   = S_CLR;
                end
            end
            S_CLR: begin
                if (r_ops_rem != '0) begin
                    w_in_ready_nxt = 1'b1;
                    w_state_nxt    = S_WR;
                end else begin
                    w_accu_nxt    = 1'b1;
                    w_acc_cnt_nxt = '0;
                    w_state_nxt   = S_ACC;
                end
            end
            S_WR: begin
                w_in_ready_nxt = 1'b1;
                if (w_hs) begin
                    w_datos_in_nxt  = in_data;
                    w_ena_write_nxt = 1'b1;
                    w_ops_rem_nxt   = r_ops_rem - 1'b1;
                    // Last operand: drop in_ready on the very next cycle.
                    if (r_ops_rem == CNT_W'(1)) begin
                        w_in_ready_nxt = 1'b0;
                        w_accu_nxt     = 1'b1;
                        w_acc_cnt_nxt  = '0;
                        w_state_nxt    = S_ACC;
                    end
                end
            end
            S_ACC: begin
                // r_acc_cnt counts cycles already spent with enable_accu high.
                if (r_acc_cnt == ACC_W'(ACC_CYCLES - 1)) begin
                    if (r_res_rem != '0) begin
                        w_ena_read_nxt = 1'b1;
                        w_state_nxt    = S_RD_REQ;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_accu_nxt    = 1'b1;
                    w_acc_cnt_nxt = r_acc_cnt + 1'b1;
                end
            end
            S_RD_REQ: begin
`ifdef TFE_DRV_TIMEOUT_EN
                w_to_cnt_nxt = '0;
`endif
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (core_ena_out) begin
                    w_res_data_nxt  = core_datos_out;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_RD_HOLD;
                end
`ifdef TFE_DRV_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    // Abandon this and all remaining reads of the job.
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
`endif
            end
            S_RD_HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_res_rem_nxt   = r_res_rem - 1'b1;
                    if (r_res_rem == CNT_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ena_read_nxt = 1'b1;
                        w_state_nxt    = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ops_rem   <= '0;
            r_res_rem   <= '0;
            r_acc_cnt   <= '0;
            r_in_ready  <= 1'b0;
            r_datos_in  <= 8'h00;
            r_ena_write <= 1'b0;
            r_clear     <= 1'b0;
            r_accu      <= 1'b0;
            r_ena_read  <= 1'b0;
            r_res_data  <= 8'h00;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ops_rem   <= w_ops_rem_nxt;
            r_res_rem   <= w_res_rem_nxt;
            r_acc_cnt   <= w_acc_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_datos_in  <= w_datos_in_nxt;
            r_ena_write <= w_ena_write_nxt;
            r_clear     <= w_clear_nxt;
            r_accu      <= w_accu_nxt;
            r_ena_read  <= w_ena_read_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

`ifdef TFE_DRV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`endif

    assign in_ready         = r_in_ready;
    assign core_datos_in    = r_datos_in;
    assign core_ena_write   = r_ena_write;
    assign core_clear       = r_clear;
    assign core_enable_accu = r_accu;
    assign core_ena_read    = r_ena_read;
    assign res_data         = r_res_data;
    assign res_valid        = r_res_valid;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;

endmodule

// File: tb/tb_tfe_host_driver.sv
// tb/tb_tfe_host_driver.sv - self-checking bench for tfe_host_driver
//
// Purpose:
//   Drives jobs into tfe_host_driver using a randomized operand source, a randomized
//   core responder and a randomized result sink. An event-scheduled reference model
//   predicts every output on every cycle, and a few jobs are pinned with
//   hand-computed counts. TFE_DRV_TIMEOUT_EN selects the timeout job.
//
// Ports: none (top-level bench).

module tb_tfe_host_driver;

    localparam int CNT_W      = 4;
    localparam int ACC_CYCLES = 4;
    localparam int TIMEOUT    = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_ops = '0;
    logic [CNT_W-1:0] n_res = '0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       core_datos_in;
    logic             core_ena_write;
    logic             core_clear;
    logic             core_enable_accu;
    logic             core_ena_read;
    logic [7:0]       core_datos_out = 8'h00;
    logic             core_ena_out = 1'b0;
    logic [7:0]       res_data;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             err;

    tfe_host_driver #(.CNT_W(CNT_W), .ACC_CYCLES(ACC_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_ops(n_ops), .n_res(n_res),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_datos_in(core_datos_in), .core_ena_write(core_ena_write),
        .core_clear(core_clear), .core_enable_accu(core_enable_accu),
        .core_ena_read(core_ena_read), .core_datos_out(core_datos_out),
        .core_ena_out(core_ena_out), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs (written by the test sequence only).
    int         valid_mode = 0;      // 0 off, 1 always, 2 one of three cycles, 3 random
    int         valid_pct = 100;
    int         ready_pct = 100;
    bit         use_list = 1'b0;
    bit         core_fixed = 1'b0;
    bit         core_silent = 1'b0;
    logic [7:0] core_byte = 8'h00;
    logic [7:0] blist [3];

    // Reference model state (written by the compare process only).
    int         cyc = 0;
    int         hs_idx = 0;
    logic       m_busy = 1'b0, m_clear = 1'b0, m_in_ready = 1'b0, m_wr = 1'b0;
    logic       m_read = 1'b0, m_waiting = 1'b0, m_res_valid = 1'b0;
    logic       m_done = 1'b0, m_err = 1'b0;
    logic [7:0] m_datos = 8'h00, m_res_data = 8'h00;
    int         m_wr_rem = 0, m_acc_left = 0, m_rd_rem = 0, m_wait_cnt = 0;
    int         j_ops = 0, j_res = 0;

    // Per-job observations of the DUT, used by the hand-computed pins.
    int         o_clears = 0, o_writes = 0, o_accu = 0, o_reads = 0, o_dones = 0;
    int         o_clr_cyc = 0, o_done_cyc = 0;
    logic [7:0] o_wlog [$];
    logic [7:0] o_acc_bytes [$];

    always @(negedge clk) begin : cmp
        logic       n_busy, n_clear, n_in_ready, n_wr, n_read, n_waiting, n_res_valid;
        logic       n_done, n_err;
        logic [7:0] n_datos, n_res_data;
        int         n_wr_rem, n_acc_left, n_rd_rem, n_wait_cnt;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_busy = 0; m_clear = 0; m_in_ready = 0; m_wr = 0; m_read = 0;
            m_waiting = 0; m_res_valid = 0; m_done = 0; m_err = 0;
            m_datos = 8'h00; m_res_data = 8'h00;
            m_wr_rem = 0; m_acc_left = 0; m_rd_rem = 0; m_wait_cnt = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("core_clear", core_clear, m_clear);
            chk("in_ready", in_ready, m_in_ready);
            chk("core_ena_write", core_ena_write, m_wr);
            chk("core_datos_in", core_datos_in, m_datos);
            chk("core_enable_accu", core_enable_accu, m_acc_left > 0);
            chk("core_ena_read", core_ena_read, m_read);
            chk("res_valid", res_valid, m_res_valid);
            chk("res_data", res_data, m_res_data);
            chk("done", done, m_done);
            chk("err", err, m_err);

            if (core_clear) begin o_clears++; o_clr_cyc = cyc; end
            if (core_ena_write) begin o_writes++; o_wlog.push_back(core_datos_in); end
            if (core_enable_accu) o_accu++;
            if (core_ena_read) o_reads++;
            if (done) begin o_dones++; o_done_cyc = cyc; end
            if (res_valid && res_ready) o_acc_bytes.push_back(res_data);

            n_busy = m_busy; n_clear = 0; n_in_ready = m_in_ready; n_wr = 0;
            n_datos = m_datos; n_acc_left = m_acc_left; n_read = 0;
            n_waiting = m_waiting; n_wait_cnt = m_wait_cnt; n_res_valid = m_res_valid;
            n_res_data = m_res_data; n_rd_rem = m_rd_rem; n_wr_rem = m_wr_rem;
            n_done = 0; n_err = m_err;

            if (!m_busy && start) begin
                n_busy = 1; n_clear = 1; n_err = 0;
                j_ops = int'(n_ops); j_res = int'(n_res);
                o_clears = 0; o_writes = 0; o_accu = 0; o_reads = 0; o_dones = 0;
                o_wlog.delete(); o_acc_bytes.delete(); hs_idx = 0;
            end
            if (m_clear) begin
                if (j_ops > 0) begin n_in_ready = 1; n_wr_rem = j_ops; end
                else n_acc_left = ACC_CYCLES;
            end
            if (m_in_ready && in_valid) begin
                n_wr = 1; n_datos = in_data; n_wr_rem = m_wr_rem - 1; hs_idx++;
                if (n_wr_rem == 0) begin n_in_ready = 0; n_acc_left = ACC_CYCLES; end
            end
            if (m_acc_left > 0) begin
                n_acc_left = m_acc_left - 1;
                if (m_acc_left == 1) begin
                    if (j_res > 0) begin n_read = 1; n_rd_rem = j_res; end
                    else n_done = 1;
                end
            end
            if (m_read) begin n_waiting = 1; n_wait_cnt = 0; end
            if (m_waiting) begin
                if (core_ena_out) begin
                    n_waiting = 0; n_res_valid = 1; n_res_data = core_datos_out;
                end else begin
                    n_wait_cnt = m_wait_cnt + 1;
`ifdef TFE_DRV_TIMEOUT_EN
                    if (n_wait_cnt == TIMEOUT) begin
                        n_waiting = 0; n_err = 1; n_done = 1;
                    end
`endif
                end
            end
            if (m_res_valid && res_ready) begin
                n_res_valid = 0; n_rd_rem = m_rd_rem - 1;
                if (n_rd_rem == 0) n_done = 1;
                else n_read = 1;
            end
            if (m_done) n_busy = 0;

            m_busy = n_busy; m_clear = n_clear; m_in_ready = n_in_ready; m_wr = n_wr;
            m_datos = n_datos; m_acc_left = n_acc_left; m_read = n_read;
            m_waiting = n_waiting; m_wait_cnt = n_wait_cnt; m_res_valid = n_res_valid;
            m_res_data = n_res_data; m_rd_rem = n_rd_rem; m_wr_rem = n_wr_rem;
            m_done = n_done; m_err = n_err;
        end
    end

    // Operand source, result sink and core responder, all driven after the edge.
    bit pend = 1'b0;
    int pdly = 0;
    always @(posedge clk) begin
        #1;
        case (valid_mode)
            0: in_valid = 1'b0;
            1: in_valid = 1'b1;
            2: in_valid = (cyc % 3 == 0);
            default: in_valid = ($urandom % 100) < valid_pct;
        endcase
        if (!rst_n) in_valid = 1'b0;
        in_data   = (use_list && hs_idx < 3) ? blist[hs_idx] : 8'($urandom);
        res_ready = ($urandom % 100) < ready_pct;
        core_datos_out = 8'($urandom);
        core_ena_out   = 1'b0;
        if (!rst_n || core_silent) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pdly == 0) begin
                    core_ena_out = 1'b1;
                    if (core_fixed) core_datos_out = core_byte;
                    pend = 1'b0;
                end else begin
                    pdly--;
                end
            end else if (!core_ena_read && ($urandom % 6 == 0)) begin
                core_ena_out = 1'b1;   // stray pulse outside a read, must be ignored
            end
            if (core_ena_read) begin
                pend = 1'b1;
                pdly = int'($urandom % 4);
            end
        end
    end

    task automatic pulse_start(input int ops, input int res);
        @(posedge clk); #1;
        start = 1'b1; n_ops = CNT_W'(ops); n_res = CNT_W'(res);
        @(posedge clk); #1;
        start = 1'b0; n_ops = CNT_W'($urandom); n_res = CNT_W'($urandom);
    endtask

    // Waits for done, poking start while busy; it must be ignored.
    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (done) begin start = 1'b0; seen = 1'b1; break; end
            start = busy && ($urandom % 8 == 0);
            n_ops = CNT_W'($urandom); n_res = CNT_W'($urandom);
        end
        start = 1'b0;
        chk("job_done_in_bound", seen, 1'b1);
        @(negedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        blist[0] = 8'h11; blist[1] = 8'h22; blist[2] = 8'h33;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_clear", core_clear, 1'b0);

        // Reset mid-WR, then a clean job.
        valid_mode = 0;
        pulse_start(5, 1);
        repeat (3) @(posedge clk);
        #1 chk("t1_in_ready_in_wr", in_ready, 1'b1);
        chk("t1_busy_in_wr", busy, 1'b1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t1_async_busy", busy, 1'b0);
        chk("t1_async_in_ready", in_ready, 1'b0);
        chk("t1_async_outputs", {core_datos_in, res_data, core_ena_write, core_clear,
                                 core_enable_accu, core_ena_read, res_valid, done, err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        valid_mode = 3; valid_pct = 60;
        pulse_start(2, 1);
        wait_done(300);
        chk("t1_clean_writes", o_writes, 2);
        chk("t1_clean_dones", o_dones, 1);

        // Basic job with fixed bytes and a fixed core result.
        valid_mode = 1; use_list = 1'b1; core_fixed = 1'b1; core_byte = 8'hA5;
        pulse_start(3, 1);
        wait_done(300);
        chk("t2_clears", o_clears, 1);
        chk("t2_writes", o_writes, 3);
        chk("t2_wbytes", {o_wlog[0], o_wlog[1], o_wlog[2]}, 24'h112233);
        chk("t2_accu_cycles", o_accu, 4);
        chk("t2_reads", o_reads, 1);
        chk("t2_result", o_acc_bytes[0], 8'hA5);
        chk("t2_dones", o_dones, 1);
        use_list = 1'b0; core_fixed = 1'b0;

        // Gapped operand stream.
        valid_mode = 2;
        pulse_start(5, 1);
        wait_done(300);
        chk("t3_writes", o_writes, 5);

        // Back-pressured results.
        valid_mode = 1; ready_pct = 0;
        pulse_start(1, 2);
        begin
            bit rose = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(posedge clk); #1;
                if (res_valid) begin rose = 1'b1; break; end
            end
            chk("t4_res_valid_rise", rose, 1'b1);
        end
        repeat (10) @(posedge clk);
        #1 chk("t4_valid_held", res_valid, 1'b1);
        chk("t4_single_read", o_reads, 1);
        ready_pct = 100;
        wait_done(300);
        chk("t4_reads", o_reads, 2);
        chk("t4_accepts", o_acc_bytes.size(), 2);

        // Minimum job.
        pulse_start(0, 0);
        wait_done(100);
        chk("t5_writes", o_writes, 0);
        chk("t5_reads", o_reads, 0);
        chk("t5_accu_cycles", o_accu, ACC_CYCLES);
        chk("t5_clear_to_done", o_done_cyc - o_clr_cyc, ACC_CYCLES + 1);

        // Randomized jobs.
        for (int j = 0; j < 14; j++) begin
            valid_mode = 3;
            valid_pct = 30 + int'($urandom % 71);
            ready_pct = 30 + int'($urandom % 71);
            pulse_start(int'($urandom % 16), int'($urandom % 4));
            wait_done(3000);
        end

`ifdef TFE_DRV_TIMEOUT_EN
        // Core never answers.
        ready_pct = 100; core_silent = 1'b1;
        pulse_start(0, 2);
        wait_done(TIMEOUT + 60);
        chk("t6_err_set", err, 1'b1);
        chk("t6_reads", o_reads, 1);
        chk("t6_no_results", o_acc_bytes.size(), 0);
        core_silent = 1'b0;
        pulse_start(0, 0);
        #1 chk("t6_err_cleared", err, 1'b0);
        wait_done(100);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
